// File: rtl/ccc_dyncfg_ctrl_pkg.sv
// Shared definitions for the CCC dynamic-configuration sequencer: FSM state
// encoding and the configuration-word field map, so the APB register bank and
// the bench assemble words the same way.
package ccc_dyncfg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_LO  = 3'd1,
        ST_SHIFT_HI  = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_LOCK_WAIT = 3'd4
    } state_t;

    localparam int CFG_W_DEF = 81;

    // Field offsets/widths inside the configuration word (bit 0 shifts first).
    localparam int FINDIV_OFF = 0;   localparam int FINDIV_W = 7;
    localparam int FBDIV_OFF  = 7;   localparam int FBDIV_W  = 7;
    localparam int OADIV_OFF  = 14;  localparam int OXDIV_W  = 5;
    localparam int OBDIV_OFF  = 19;
    localparam int OCDIV_OFF  = 24;
    localparam int OAMUX_OFF  = 29;  localparam int OXMUX_W  = 3;
    localparam int OBMUX_OFF  = 32;
    localparam int OCMUX_OFF  = 35;
    localparam int FBSEL_OFF  = 38;  localparam int FBSEL_W  = 2;
    localparam int DLYGLA_OFF = 40;  localparam int DLYGL_W  = 5;
    localparam int DLYGLB_OFF = 45;
    localparam int DLYGLC_OFF = 50;
    // Bits 55..80 are reserved and built as zero.

    function automatic logic [CFG_W_DEF-1:0] build_cfg_word(
        input logic [6:0] findiv,
        input logic [6:0] fbdiv,
        input logic [4:0] oadiv,
        input logic [4:0] obdiv,
        input logic [4:0] ocdiv,
        input logic [2:0] oamux,
        input logic [2:0] obmux,
        input logic [2:0] ocmux,
        input logic [1:0] fbsel,
        input logic [4:0] dlygla,
        input logic [4:0] dlyglb,
        input logic [4:0] dlyglc
    );
        logic [CFG_W_DEF-1:0] w;
        w = '0;
        w[FINDIV_OFF +: FINDIV_W] = findiv;
        w[FBDIV_OFF  +: FBDIV_W]  = fbdiv;
        w[OADIV_OFF  +: OXDIV_W]  = oadiv;
        w[OBDIV_OFF  +: OXDIV_W]  = obdiv;
        w[OCDIV_OFF  +: OXDIV_W]  = ocdiv;
        w[OAMUX_OFF  +: OXMUX_W]  = oamux;
        w[OBMUX_OFF  +: OXMUX_W]  = obmux;
        w[OCMUX_OFF  +: OXMUX_W]  = ocmux;
        w[FBSEL_OFF  +: FBSEL_W]  = fbsel;
        w[DLYGLA_OFF +: DLYGL_W]  = dlygla;
        w[DLYGLB_OFF +: DLYGL_W]  = dlyglb;
        w[DLYGLC_OFF +: DLYGL_W]  = dlyglc;
        return w;
    endfunction

endpackage

// File: rtl/ccc_dyncfg_ctrl_if.sv
// Fabric request bus plus CCC dynamic-configuration pins.
//
// Handshake: a request is accepted at a rising FAB_CLK edge where CFG_REQ=1
// and CFG_READY=1; CFG_WORD is sampled only at that edge. CFG_READY is high
// only while the sequencer is idle, and a request seen while CFG_READY=0 is
// dropped, not queued. Completion is reported by a one-cycle CFG_DONE (lock
// qualified) or CFG_ERR (lock timeout) pulse.
interface ccc_dyncfg_ctrl_if #(
    parameter int CFG_W = 81
);
    logic             CFG_REQ;
    logic [CFG_W-1:0] CFG_WORD;
    logic             CFG_READY;
    logic             CFG_DONE;
    logic             CFG_ERR;
    logic             CCC_LOCK;
    logic             CCC_MODE;
    logic             CCC_SCLK;
    logic             CCC_SSHIFT;
    logic             CCC_SDIN;
    logic             CCC_SUPDATE;

    // Fabric master and CCC lock source.
    modport master (
        output CFG_REQ, CFG_WORD, CCC_LOCK,
        input  CFG_READY, CFG_DONE, CFG_ERR,
        input  CCC_MODE, CCC_SCLK, CCC_SSHIFT, CCC_SDIN, CCC_SUPDATE
    );

    // Sequencer.
    modport slave (
        input  CFG_REQ, CFG_WORD, CCC_LOCK,
        output CFG_READY, CFG_DONE, CFG_ERR,
        output CCC_MODE, CCC_SCLK, CCC_SSHIFT, CCC_SDIN, CCC_SUPDATE
    );
endinterface

// File: rtl/ccc_lock_monitor.sv
// PLL lock qualifier: synchronizes the raw lock, ignores it during a blanking
// window after update, then requires a run of consecutive locked cycles. A
// timeout bounds the whole wait; done has priority over err.
module ccc_lock_monitor #(
    parameter int LOCK_BLANK   = 32,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_lock_raw,
    output logic o_done,
    output logic o_err
);
    localparam int WAIT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STAB_W = $clog2(LOCK_STABLE + 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_active;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [STAB_W-1:0] r_stable_cnt;

    logic [WAIT_W-1:0] w_wait_inc;
    logic [STAB_W-1:0] w_stable_nxt;
    logic              w_counting;

    // Next counter values and the done/err decisions for the current cycle.
    always_comb begin
        w_wait_inc   = r_wait_cnt + WAIT_W'(1);
        w_counting   = (r_wait_cnt >= WAIT_W'(LOCK_BLANK));
        w_stable_nxt = '0;
        if (w_counting && r_sync2) begin
            w_stable_nxt = r_stable_cnt + STAB_W'(1);
        end
        o_done = r_active && (w_stable_nxt == STAB_W'(LOCK_STABLE));
        o_err  = r_active && !o_done && (w_wait_inc == WAIT_W'(LOCK_TIMEOUT));
    end

    // Two-flop lock synchronizer and the wait/stable counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_active     <= 1'b0;
            r_wait_cnt   <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_sync1 <= i_lock_raw;
            r_sync2 <= r_sync1;
            if (i_start) begin
                r_active     <= 1'b1;
                r_wait_cnt   <= '0;
                r_stable_cnt <= '0;
            end else if (r_active) begin
                r_wait_cnt   <= w_wait_inc;
                r_stable_cnt <= w_stable_nxt;
                if (o_done || o_err) begin
                    r_active <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// CCC dynamic-configuration sequencer: shifts a configuration word LSB first
// into the CCC, pulses SUPDATE, then waits for qualified PLL lock. All CCC_*
// pins come straight from flops loaded with next-state decode, so they change
// together with the state register.
module ccc_dyncfg_ctrl
    import ccc_dyncfg_ctrl_pkg::*;
#(
    parameter int CFG_W        = 81,
    parameter int SCLK_HALF    = 2,
    parameter int LOCK_BLANK   = 32,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic               FAB_CLK,
    input  logic               FAB_RESET,
    ccc_dyncfg_ctrl_if.slave   bus,
    output state_t             o_dbg_state
);
    localparam int HALF_W = $clog2(SCLK_HALF + 1);
    localparam int BIT_W  = $clog2(CFG_W + 1);

    if (LOCK_TIMEOUT <= LOCK_BLANK + LOCK_STABLE) begin : g_bad_timeout
        $error("ccc_dyncfg_ctrl: LOCK_TIMEOUT must exceed LOCK_BLANK + LOCK_STABLE");
    end
    if (SCLK_HALF < 1) begin : g_bad_sclk_half
        $error("ccc_dyncfg_ctrl: SCLK_HALF must be at least 1");
    end

    state_t            r_state;
    logic [HALF_W-1:0] r_half;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [CFG_W-1:0]  r_shadow;
    logic              r_mode;
    logic              r_sclk;
    logic              r_sshift;
    logic              r_sdin;
    logic              r_supdate;
    logic              r_done;
    logic              r_err;

    state_t            w_state_nxt;
    logic [HALF_W-1:0] w_half_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [CFG_W-1:0]  w_shadow_nxt;
    logic              w_half_end;
    logic              w_mon_start;
    logic              w_mon_done;
    logic              w_mon_err;

    ccc_lock_monitor #(
        .LOCK_BLANK   (LOCK_BLANK),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_mon (
        .i_clk      (FAB_CLK),
        .i_rst      (FAB_RESET),
        .i_start    (w_mon_start),
        .i_lock_raw (bus.CCC_LOCK),
        .o_done     (w_mon_done),
        .o_err      (w_mon_err)
    );

    // Next-state, phase/bit counters and shadow register update.
    always_comb begin
        w_state_nxt  = r_state;
        w_half_nxt   = r_half;
        w_bit_nxt    = r_bit_cnt;
        w_shadow_nxt = r_shadow;
        w_mon_start  = 1'b0;
        w_half_end   = (r_half == HALF_W'(SCLK_HALF - 1));
        case (r_state)
            ST_IDLE: begin
                if (bus.CFG_REQ) begin
                    w_state_nxt  = ST_SHIFT_LO;
                    w_shadow_nxt = bus.CFG_WORD;
                    w_bit_nxt    = '0;
                    w_half_nxt   = '0;
                end
            end
            ST_SHIFT_LO: begin
                if (w_half_end) begin
                    w_state_nxt = ST_SHIFT_HI;
                    w_half_nxt  = '0;
                end else begin
                    w_half_nxt = r_half + HALF_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (w_half_end) begin
                    w_half_nxt   = '0;
                    w_shadow_nxt = r_shadow >> 1;
                    w_bit_nxt    = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_W'(CFG_W - 1)) begin
                        w_state_nxt = ST_UPDATE;
                    end else begin
                        w_state_nxt = ST_SHIFT_LO;
                    end
                end else begin
                    w_half_nxt = r_half + HALF_W'(1);
                end
            end
            ST_UPDATE: begin
                if (w_half_end) begin
                    w_half_nxt  = '0;
                    w_state_nxt = ST_LOCK_WAIT;
                    w_mon_start = 1'b1;
                end else begin
                    w_half_nxt = r_half + HALF_W'(1);
                end
            end
            ST_LOCK_WAIT: begin
                if (w_mon_done || w_mon_err) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters, shadow and registered CCC/status outputs.
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            r_state   <= ST_IDLE;
            r_half    <= '0;
            r_bit_cnt <= '0;
            r_shadow  <= '0;
            r_mode    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sshift  <= 1'b0;
            r_sdin    <= 1'b0;
            r_supdate <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_half    <= w_half_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shadow  <= w_shadow_nxt;
            // Dynamic mode latches on the first accepted request.
            if (r_state == ST_IDLE && bus.CFG_REQ) begin
                r_mode <= 1'b1;
            end
            r_sshift  <= (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI);
            r_sclk    <= (w_state_nxt == ST_SHIFT_HI);
            r_sdin    <= ((w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI))
                         ? w_shadow_nxt[0] : 1'b0;
            r_supdate <= (w_state_nxt == ST_UPDATE);
            r_done    <= (r_state == ST_LOCK_WAIT) && w_mon_done;
            r_err     <= (r_state == ST_LOCK_WAIT) && w_mon_err && !w_mon_done;
        end
    end

    assign bus.CFG_READY   = (r_state == ST_IDLE);
    assign bus.CFG_DONE    = r_done;
    assign bus.CFG_ERR     = r_err;
    assign bus.CCC_MODE    = r_mode;
    assign bus.CCC_SCLK    = r_sclk;
    assign bus.CCC_SSHIFT  = r_sshift;
    assign bus.CCC_SDIN    = r_sdin;
    assign bus.CCC_SUPDATE = r_supdate;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_ccc_dyncfg_ctrl.sv
// Bench for ccc_dyncfg_ctrl: a small instance (8-bit word, SCLK_HALF=1,
// timeout 100) driven from a vector table, plus hand sequences for reset
// mid-shift and a full 81-bit word on a default-parameter instance.
module tb_ccc_dyncfg_ctrl;
    import ccc_dyncfg_ctrl_pkg::*;

    localparam int AW = 8;
    localparam int BW = 81;

    typedef struct {
        logic [AW-1:0] word;
        int            lock_mode;   // 0: held low, 1: held high, 2: glitch pattern
        bit            inject;      // second request during shifting
        int            exp_done;    // negedge count after accept, -1 = none
        int            exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    state_t dbg_a;
    state_t dbg_b;

    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    ccc_dyncfg_ctrl_if #(.CFG_W(AW)) bus_a();
    ccc_dyncfg_ctrl_if #(.CFG_W(BW)) bus_b();

    ccc_dyncfg_ctrl #(
        .CFG_W(AW), .SCLK_HALF(1), .LOCK_BLANK(32), .LOCK_STABLE(16), .LOCK_TIMEOUT(100)
    ) u_dut_a (
        .FAB_CLK(clk), .FAB_RESET(rst_a), .bus(bus_a.slave), .o_dbg_state(dbg_a)
    );

    ccc_dyncfg_ctrl u_dut_b (
        .FAB_CLK(clk), .FAB_RESET(rst_b), .bus(bus_b.slave), .o_dbg_state(dbg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // One transaction on instance A, observed every negedge after accept.
    task automatic run_a(input vec_t v);
        int cnt, lw, rises, upd, ssh, done_at, err_at, c;
        logic [AW-1:0] recon;
        logic prev_sclk;
        bit seen_upd;
        cnt = 0; lw = -1; rises = 0; upd = 0; ssh = 0; done_at = -1; err_at = -1;
        recon = '0; prev_sclk = 1'b0; seen_upd = 1'b0;
        for (int i = 0; i < AW; i++) exp_q.push_back(v.word[i]);
        check("ready_pre", 32'(bus_a.CFG_READY), 1);
        bus_a.CCC_LOCK = (v.lock_mode == 1);
        bus_a.CFG_WORD = v.word;
        bus_a.CFG_REQ  = 1'b1;
        @(posedge clk);
        while (cnt < 400 && done_at < 0 && err_at < 0) begin
            @(negedge clk);
            cnt++;
            if (v.inject && (cnt == 3 || cnt == 4)) begin
                bus_a.CFG_REQ  = 1'b1;
                bus_a.CFG_WORD = ~v.word;
            end else begin
                bus_a.CFG_REQ  = 1'b0;
                bus_a.CFG_WORD = v.word;
            end
            if (bus_a.CCC_SCLK && !prev_sclk) begin
                rises++;
                recon = {bus_a.CCC_SDIN, recon[AW-1:1]};
                if (exp_q.size() > 0) check("sdin_bit", 32'(bus_a.CCC_SDIN), 32'(exp_q.pop_front()));
                else check("extra_sclk", rises, AW);
            end
            prev_sclk = bus_a.CCC_SCLK;
            if (bus_a.CCC_SSHIFT) ssh++;
            if (bus_a.CCC_SUPDATE) begin
                upd++;
                seen_upd = 1'b1;
            end
            if (seen_upd && !bus_a.CCC_SUPDATE && lw < 0) lw = cnt;
            if (bus_a.CFG_DONE) done_at = cnt;
            if (bus_a.CFG_ERR) err_at = cnt;
            if (v.lock_mode == 2 && lw >= 0) begin
                c = cnt - lw;
                bus_a.CCC_LOCK = ((c >= 40 && c <= 49) || c >= 51);
            end
        end
        check("done_at", done_at, v.exp_done);
        check("err_at", err_at, v.exp_err);
        check("sclk_rises", rises, AW);
        check("sshift_cycles", ssh, 2 * AW);
        check("supdate_cycles", upd, 1);
        check("recon_word", 32'(recon), 32'(v.word));
        check("lockwait_entry", lw, 18);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        check("done_single", 32'(bus_a.CFG_DONE), 0);
        check("err_single", 32'(bus_a.CFG_ERR), 0);
        check("ready_post", 32'(bus_a.CFG_READY), 1);
        check("mode_post", 32'(bus_a.CCC_MODE), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, rises, upd, ssh, done_at, err_at, lw;
        logic [BW-1:0] word_b, recon_b;
        logic prev_sclk;
        bit seen_upd;

        vecs[0] = '{word: 8'hA5, lock_mode: 1, inject: 1'b0, exp_done: 66,  exp_err: -1};
        vecs[1] = '{word: 8'h3C, lock_mode: 1, inject: 1'b0, exp_done: 66,  exp_err: -1};
        vecs[2] = '{word: 8'h00, lock_mode: 0, inject: 1'b0, exp_done: -1,  exp_err: 118};
        vecs[3] = '{word: 8'hFF, lock_mode: 2, inject: 1'b0, exp_done: 87,  exp_err: -1};
        vecs[4] = '{word: 8'h96, lock_mode: 1, inject: 1'b1, exp_done: 66,  exp_err: -1};

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.CFG_REQ = 1'b0; bus_a.CFG_WORD = '0; bus_a.CCC_LOCK = 1'b0;
        bus_b.CFG_REQ = 1'b0; bus_b.CFG_WORD = '0; bus_b.CCC_LOCK = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("rst_ready_a", 32'(bus_a.CFG_READY), 1);
        check("rst_state_a", 32'(dbg_a), 32'(ST_IDLE));
        check("rst_mode_a", 32'(bus_a.CCC_MODE), 0);
        check("rst_sclk_a", 32'(bus_a.CCC_SCLK), 0);
        check("rst_sshift_a", 32'(bus_a.CCC_SSHIFT), 0);
        check("rst_sdin_a", 32'(bus_a.CCC_SDIN), 0);
        check("rst_supdate_a", 32'(bus_a.CCC_SUPDATE), 0);
        check("rst_done_a", 32'(bus_a.CFG_DONE), 0);
        check("rst_err_a", 32'(bus_a.CFG_ERR), 0);
        check("rst_ready_b", 32'(bus_b.CFG_READY), 1);
        check("rst_mode_b", 32'(bus_b.CCC_MODE), 0);

        for (int i = 0; i < 5; i++) run_a(vecs[i]);

        // Reset after the third SCLK rise: everything drops, no SUPDATE follows.
        bus_a.CCC_LOCK = 1'b1;
        bus_a.CFG_WORD = 8'hE7;
        bus_a.CFG_REQ  = 1'b1;
        @(posedge clk);
        rises = 0; cnt = 0; prev_sclk = 1'b0;
        while (rises < 3 && cnt < 50) begin
            @(negedge clk);
            cnt++;
            bus_a.CFG_REQ = 1'b0;
            if (bus_a.CCC_SCLK && !prev_sclk) rises++;
            prev_sclk = bus_a.CCC_SCLK;
        end
        check("rst_mid_rises", rises, 3);
        check("rst_mid_sclk_before", 32'(bus_a.CCC_SCLK), 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_mid_mode", 32'(bus_a.CCC_MODE), 0);
        check("rst_mid_sclk", 32'(bus_a.CCC_SCLK), 0);
        check("rst_mid_sshift", 32'(bus_a.CCC_SSHIFT), 0);
        check("rst_mid_sdin", 32'(bus_a.CCC_SDIN), 0);
        check("rst_mid_supdate", 32'(bus_a.CCC_SUPDATE), 0);
        check("rst_mid_done", 32'(bus_a.CFG_DONE), 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus_a.CFG_READY), 1);
        upd = 0; ssh = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus_a.CCC_SUPDATE) upd++;
            if (bus_a.CCC_SSHIFT) ssh++;
        end
        check("rst_mid_no_supdate", upd, 0);
        check("rst_mid_no_sshift", ssh, 0);

        // Full-width word on the default instance, rebuilt by a shift model.
        word_b = build_cfg_word(7'd6, 7'd6, 5'd0, 5'd1, 5'd0, 3'd0, 3'd3, 3'd0,
                                2'd0, 5'd0, 5'd0, 5'd17);
        word_b[BW-1] = 1'b1;
        bus_b.CFG_WORD = word_b;
        bus_b.CFG_REQ  = 1'b1;
        @(posedge clk);
        cnt = 0; rises = 0; upd = 0; ssh = 0; done_at = -1; err_at = -1; lw = -1;
        recon_b = '0; prev_sclk = 1'b0; seen_upd = 1'b0;
        while (cnt < 600 && done_at < 0 && err_at < 0) begin
            @(negedge clk);
            cnt++;
            bus_b.CFG_REQ = 1'b0;
            if (bus_b.CCC_SCLK && !prev_sclk) begin
                rises++;
                recon_b = {bus_b.CCC_SDIN, recon_b[BW-1:1]};
            end
            prev_sclk = bus_b.CCC_SCLK;
            if (bus_b.CCC_SSHIFT) ssh++;
            if (bus_b.CCC_SUPDATE) begin
                if (!seen_upd) begin
                    check("b_rises_at_update", rises, BW);
                    total++;
                    if (recon_b !== word_b) begin
                        bad++;
                        $display("FAIL b_recon_word: got %h want %h", recon_b, word_b);
                    end
                end
                seen_upd = 1'b1;
                upd++;
            end
            if (seen_upd && !bus_b.CCC_SUPDATE && lw < 0) lw = cnt;
            if (bus_b.CFG_DONE) done_at = cnt;
            if (bus_b.CFG_ERR) err_at = cnt;
        end
        check("b_seen_update", 32'(seen_upd), 1);
        check("b_sshift_cycles", ssh, 4 * BW);
        check("b_supdate_cycles", upd, 2);
        check("b_lockwait_entry", lw, 327);
        check("b_done_at", done_at, 375);
        check("b_err_at", err_at, -1);
        @(negedge clk);
        check("b_ready_post", 32'(bus_b.CFG_READY), 1);
        check("b_mode_post", 32'(bus_b.CCC_MODE), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ccc_dyncfg_ctrl.md
Name: ccc_dyncfg_ctrl

Overview:
Fabric-side sequencer that reprograms the MSS clock conditioning circuit (CCC/PLL) at run time through its serial dynamic-configuration interface. It takes a configuration word holding the FINDIV, FBDIV, OxDIV, OxMUX, DLYGLx and FBSEL fields from a fabric master. It shifts the word into the CCC, pulses update, then qualifies PLL lock before reporting done or timeout. It sits between the fabric APB register bank and the CCC dynamic-config pins.

Parameters:
CFG_W, 81, configuration word width (bits shifted per transaction)
SCLK_HALF, 2, FAB_CLK cycles per CCC_SCLK half-period (>=1)
LOCK_BLANK, 32, cycles after update during which lock is ignored
LOCK_STABLE, 16, consecutive synced-lock cycles required for success
LOCK_TIMEOUT, 65535, max cycles in lock wait (includes blank) before error

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
FAB_RESET  in  1  synchronous, active-high reset
CFG_REQ  in  1  request; accepted when CFG_REQ=1 and CFG_READY=1 at an edge
CFG_WORD  in  CFG_W  configuration word, sampled only on accept
CFG_READY  out  1  1 only in IDLE
CFG_DONE  out  1  one-cycle pulse: lock qualified
CFG_ERR  out  1  one-cycle pulse: lock timeout
CCC_LOCK  in  1  raw PLL lock (asynchronous)
CCC_MODE  out  1  selects dynamic configuration in CCC
CCC_SCLK  out  1  serial config clock
CCC_SSHIFT  out  1  shift enable
CCC_SDIN  out  1  serial data
CCC_SUPDATE  out  1  transfer shift register to active config

Behaviour:
- Reset: CFG_DONE, CFG_ERR, CCC_MODE, CCC_SCLK, CCC_SSHIFT, CCC_SDIN, CCC_SUPDATE = 0. State IDLE, so CFG_READY=1 in the first cycle after reset. Internal counters and shadow register cleared.
- All CCC_* outputs are registered, with no combinational path from inputs.
- CCC_LOCK passes through a 2-flop synchronizer; only the synced value is used.
- FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (repeat per bit) -> UPDATE -> LOCK_WAIT -> IDLE.
- IDLE: on accept, capture CFG_WORD into the shadow register, clear the bit counter, go to SHIFT_LO. CCC_MODE is set to 1 and stays 1 until reset.
- SHIFT_LO (SCLK_HALF cycles): CCC_SSHIFT=1, CCC_SCLK=0, CCC_SDIN=shadow[0]. Bits go LSB first.
- SHIFT_HI (SCLK_HALF cycles): CCC_SCLK=1, SDIN held stable. On exit, shadow shifts right by one and the bit counter increments. If the counter reaches CFG_W, go to UPDATE; otherwise go to SHIFT_LO.
- CCC_SSHIFT rises on the first edge after accept. Exactly CFG_W rising SCLK edges occur per transaction.
- UPDATE (SCLK_HALF cycles): CCC_SSHIFT=0, CCC_SCLK=0, CCC_SUPDATE=1, CCC_SDIN=0. Then go to LOCK_WAIT.
- LOCK_WAIT: the wait counter increments every cycle.
  - For the first LOCK_BLANK cycles, lock is ignored.
  - After blanking, the stable counter increments while synced lock=1 and clears when it drops.
  - Stable counter = LOCK_STABLE: pulse CFG_DONE, go to IDLE.
  - Wait counter = LOCK_TIMEOUT: pulse CFG_ERR, go to IDLE.
  - If both happen on the same cycle, DONE wins.
- CFG_REQ while not in IDLE is ignored (no queue). CFG_REQ held high through completion starts a new transaction on the first IDLE cycle.
- Reset mid-shift or mid-update: outputs return to reset values on that edge. SUPDATE was never asserted, so the CCC keeps its previous active configuration.
- Counter widths are $clog2(max+1). LOCK_TIMEOUT must be > LOCK_BLANK + LOCK_STABLE; check this with an elaboration-time assertion.

Decomposition:
- Shared include ccc_cfg_defs.vh holds:
  - FSM state encodings;
  - CFG_WORD field offsets and widths (FINDIV[6:0], FBDIV[6:0], OADIV/OBDIV/OCDIV[4:0], OAMUX/OBMUX/OCMUX[2:0], FBSEL[1:0], DLYGLx[4:0]) so the register bank and the bench build words identically.
- One sub-module, ccc_lock_monitor, holds the synchronizer plus the blank, stable and timeout counters. Interface: start, done, err.

Test Plan:
- CFG_W=8, SCLK_HALF=1, CFG_WORD=8'hA5, CCC_LOCK tied 1 -> SDIN samples at SCLK rises = 1,0,1,0,0,1,0,1. SUPDATE high 1 cycle. CFG_DONE at accept+16+1+LOCK_BLANK+LOCK_STABLE (+sync).
- CCC_LOCK held 0, LOCK_TIMEOUT=100 -> CFG_ERR single pulse exactly 100 cycles after entering LOCK_WAIT, no CFG_DONE, CFG_READY=1 next cycle.
- Lock toggles 1 for 10 cycles, 0 for 1 cycle, then stays 1 (LOCK_STABLE=16) -> DONE only after 16 uninterrupted cycles.
- CFG_REQ pulsed again during SHIFT with a different word -> ignored; shifted bits match the first word only.
- FAB_RESET asserted after 3 SCLK rises -> all CCC_* outputs 0 next edge, SUPDATE never seen, CFG_READY=1 after release.
- Default parameters, full 81-bit word with FINDIV=6, FBDIV=6, OBDIV=1, OBMUX=3 -> bench shift-register model reconstructs identical word at SUPDATE.
